fifo_skew_sched: RTL and testbench

//  Sequences a bank of DIM delay-buffer FIFOs (depth DIM, shift-on-en) feeding the systolic MAC array.

---
 rtl/fifo_sched_pkg.sv | 20 ++
 rtl/fifo_skew_sched_skew_en_gen.sv | 18 +
 rtl/fifo_skew_sched.sv | 149 ++++++++++++++
 tb/tb_fifo_skew_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared state encoding and counter-width helpers for the FIFO skew scheduler.
package fifo_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        COMPUTE,
        DRAIN,
        DONE
    } state_e;

    function automatic int beat_w(input int dim);
        return $clog2(dim * dim + 1);
    endfunction

    function automatic int cyc_w(input int dim);
        return $clog2(2 * dim);
    endfunction

endpackage

// File: rtl/fifo_skew_sched_skew_en_gen.sv
// Diagonal window decode: lane i is live while i <= c < i+DIM and the array can advance.
module skew_en_gen #(
    parameter int DIM = 8,
    parameter int CW  = 4
) (
    input  logic [CW-1:0]  c,
    input  logic           mac_ready,
    output logic [DIM-1:0] col_valid
);

    genvar i;
    generate
        for (i = 0; i < DIM; i++) begin : g_lane
            assign col_valid[i] = mac_ready && (int'(c) >= i) && (int'(c) < i + DIM);
        end
    endgenerate

endmodule

// File: rtl/fifo_skew_sched.sv
// Fill/skew/drain sequencer for the DIM x DIM delay-FIFO bank feeding the MAC array.
// Optional stall_cnt perf counter enabled by defining FIFO_SKEW_SCHED_PERF_EN.
module fifo_skew_sched
    import fifo_sched_pkg::*;
#(
    parameter int DIM  = 8,
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    output logic [BITS-1:0] fifo_d,
    output logic [DIM-1:0]  fifo_en,
    output logic [DIM-1:0]  col_valid,
    input  logic            mac_ready,
    output logic            mac_en,
    output logic            busy,
    output logic            done
`ifdef FIFO_SKEW_SCHED_PERF_EN
   ,output logic [31:0]     stall_cnt
`endif
);

    localparam int BW         = beat_w(DIM);
    localparam int CW         = cyc_w(DIM);
    localparam int LAST_BEAT  = DIM * DIM - 1;
    localparam int LAST_C     = 2 * DIM - 2;
    localparam int LAST_DRAIN = DIM - 1;

    state_e         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [CW-1:0]  c_q, c_d;
    logic [DIM-1:0] win;
    logic [DIM-1:0] fill_en;

    skew_en_gen #(
        .DIM (DIM),
        .CW  (CW)
    ) u_skew (
        .c         (c_q),
        .mac_ready (mac_ready),
        .col_valid (win)
    );

    // c_q is reused as the drain counter once the skew window has fully passed.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        c_d     = c_q;
        if (clr) begin
            state_d = IDLE;
            beat_d  = '0;
            c_d     = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = FILL;
                    beat_d  = '0;
                    c_d     = '0;
                end
                FILL: if (in_valid) begin
                    if (int'(beat_q) == LAST_BEAT) begin
                        state_d = COMPUTE;
                        beat_d  = '0;
                        c_d     = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                COMPUTE: if (mac_ready) begin
                    if (int'(c_q) == LAST_C) begin
                        state_d = DRAIN;
                        c_d     = '0;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                DRAIN: if (mac_ready) begin
                    if (int'(c_q) == LAST_DRAIN) begin
                        state_d = DONE;
                        c_d     = '0;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            c_q     <= c_d;
        end
    end

    // Beat b lands in FIFO b/DIM; range compare avoids a divider.
    always_comb begin
        fill_en = '0;
        for (int i = 0; i < DIM; i++) begin
            fill_en[i] = (int'(beat_q) >= i * DIM) && (int'(beat_q) < (i + 1) * DIM);
        end
    end

    always_comb begin
        in_ready  = (state_q == FILL);
        fifo_d    = (state_q == FILL) ? in_data : '0;
        col_valid = (state_q == COMPUTE) ? win : '0;
        fifo_en   = '0;
        if (state_q == FILL && in_valid) fifo_en = fill_en;
        else if (state_q == COMPUTE)     fifo_en = win;
        mac_en    = (state_q == COMPUTE || state_q == DRAIN) && mac_ready;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

`ifdef FIFO_SKEW_SCHED_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start && !clr) begin
            stall_cnt_d = '0;
        end else if ((state_q == COMPUTE || state_q == DRAIN) && !mac_ready
                     && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_skew_sched.sv
// Directed bench for fifo_skew_sched at DIM=4, BITS=8; perf checks need FIFO_SKEW_SCHED_PERF_EN.
module tb_fifo_skew_sched;

    localparam int DIM  = 4;
    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            mac_ready = 1'b1;
    logic            in_ready;
    logic [BITS-1:0] fifo_d;
    logic [DIM-1:0]  fifo_en;
    logic [DIM-1:0]  col_valid;
    logic            mac_en;
    logic            busy;
    logic            done;
`ifdef FIFO_SKEW_SCHED_PERF_EN
    logic [31:0]     stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] win_exp [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    fifo_skew_sched #(
        .DIM  (DIM),
        .BITS (BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fifo_d    (fifo_d),
        .fifo_en   (fifo_en),
        .col_valid (col_valid),
        .mac_ready (mac_ready),
        .mac_en    (mac_en),
        .busy      (busy),
        .done      (done)
`ifdef FIFO_SKEW_SCHED_PERF_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic fill_words;
        for (int b = 0; b < DIM * DIM; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(b);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_chk++;
        if ({in_ready, fifo_d, fifo_en, col_valid, mac_en, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required 0",
                     {in_ready, fifo_d, fifo_en, col_valid, mac_en, busy, done});
        end
        rst_n = 1'b1;
        cyc();
        n_chk++;
        if ({in_ready, fifo_d, fifo_en, col_valid, mac_en, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b required 0",
                     {in_ready, fifo_d, fifo_en, col_valid, mac_en, busy, done});
        end
    endtask

    task automatic test_fill_compute;
        start = 1'b1;
        #2;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_idle_busy: got %b required 0", busy);
        end
        cyc();
        start = 1'b0;
        for (int b = 0; b < 16; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(b);
            #2;
            n_chk++;
            if ({in_ready, fifo_en, fifo_d, col_valid, mac_en, busy} !==
                {1'b1, 4'(1 << (b / 4)), 8'(b), 4'b0000, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL fill_beat%0d: got rdy=%b en=%b d=%h cv=%b me=%b busy=%b required en=%b d=%h",
                         b, in_ready, fifo_en, fifo_d, col_valid, mac_en, busy, 4'(1 << (b / 4)), 8'(b));
            end
            cyc();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #2;
            n_chk++;
            if ({in_ready, fifo_en, col_valid, mac_en, busy, done} !==
                {1'b0, win_exp[k], win_exp[k], 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL compute_c%0d: got rdy=%b en=%b cv=%b me=%b busy=%b done=%b required cv=%b",
                         k, in_ready, fifo_en, col_valid, mac_en, busy, done, win_exp[k]);
            end
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            #2;
            n_chk++;
            if ({in_ready, fifo_en, col_valid, mac_en, busy, done} !== 12'b0_0000_0000_110) begin
                n_fail++;
                $display("FAIL drain%0d: got rdy=%b en=%b cv=%b me=%b busy=%b done=%b required en=0 cv=0 me=1 busy=1 done=0",
                         k, in_ready, fifo_en, col_valid, mac_en, busy, done);
            end
            cyc();
        end
        #2;
        n_chk++;
        if ({mac_en, busy, done} !== 3'b011) begin
            n_fail++;
            $display("FAIL done_pulse: got me=%b busy=%b done=%b required 0 1 1", mac_en, busy, done);
        end
        cyc();
        n_chk++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL after_done: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_stall;
        start_job();
        fill_words();
        for (int k = 0; k < 2; k++) cyc();
        mac_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #2;
            n_chk++;
            if ({fifo_en, col_valid, mac_en, busy} !== 10'b0000_0000_01) begin
                n_fail++;
                $display("FAIL stall%0d: got en=%b cv=%b me=%b busy=%b required en=0 cv=0 me=0 busy=1",
                         s, fifo_en, col_valid, mac_en, busy);
            end
            cyc();
        end
        mac_ready = 1'b1;
        for (int k = 2; k < 7; k++) begin
            #2;
            n_chk++;
            if ({fifo_en, col_valid, mac_en} !== {win_exp[k], win_exp[k], 1'b1}) begin
                n_fail++;
                $display("FAIL resume_c%0d: got en=%b cv=%b me=%b required cv=%b me=1",
                         k, fifo_en, col_valid, mac_en, win_exp[k]);
            end
            cyc();
        end
        for (int k = 0; k < 4; k++) cyc();
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got %b required 1", done);
        end
        cyc();
    endtask

`ifdef FIFO_SKEW_SCHED_PERF_EN
    task automatic test_perf;
        n_chk++;
        if (stall_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_held: got %0d required 3", stall_cnt);
        end
        start_job();
        n_chk++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_clear: got %0d required 0", stall_cnt);
        end
        fill_words();
        cyc();
        mac_ready = 1'b0;
        for (int s = 0; s < 5; s++) cyc();
        mac_ready = 1'b1;
        for (int k = 1; k < 7; k++) cyc();
        cyc();
        mac_ready = 1'b0;
        for (int s = 0; s < 2; s++) cyc();
        mac_ready = 1'b1;
        for (int k = 1; k < 4; k++) cyc();
        n_chk++;
        if ({done, stall_cnt} !== {1'b1, 32'd7}) begin
            n_fail++;
            $display("FAIL perf_at_done: got done=%b cnt=%0d required done=1 cnt=7", done, stall_cnt);
        end
        cyc();
    endtask
`endif

    task automatic test_gaps;
        int b;
        b = 0;
        start = 1'b1;
        cyc();
        for (int t = 0; b < 16 && t < 40; t++) begin
            in_valid = (t % 3 != 2);
            in_data  = 8'(8'hA0 + b);
            #2;
            n_chk++;
            if ({in_ready, fifo_en} !== {1'b1, in_valid ? 4'(1 << (b / 4)) : 4'b0000}) begin
                n_fail++;
                $display("FAIL gap_t%0d: got rdy=%b en=%b required rdy=1 en=%b",
                         t, in_ready, fifo_en, in_valid ? 4'(1 << (b / 4)) : 4'b0000);
            end
            if (in_valid) b++;
            cyc();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        #2;
        n_chk++;
        if ({in_ready, col_valid, busy} !== 6'b0_0001_1) begin
            n_fail++;
            $display("FAIL gap_to_compute: got rdy=%b cv=%b busy=%b required 0 0001 1", in_ready, col_valid, busy);
        end
        for (int k = 0; k < 11; k++) cyc();
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_done: got %b required 1", done);
        end
        cyc();
    endtask

    task automatic test_clr;
        logic seen_done;
        start_job();
        fill_words();
        for (int k = 0; k < 3; k++) cyc();
        clr = 1'b1;
        #2;
        n_chk++;
        if (col_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL clr_c3: got cv=%b required 1111", col_valid);
        end
        cyc();
        clr = 1'b0;
        n_chk++;
        if ({busy, done, in_ready, fifo_en, col_valid, mac_en} !== 12'd0) begin
            n_fail++;
            $display("FAIL clr_idle: got busy=%b done=%b rdy=%b en=%b cv=%b me=%b required all 0",
                     busy, done, in_ready, fifo_en, col_valid, mac_en);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            seen_done |= done;
            cyc();
        end
        n_chk++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_no_done: got %b required 0", seen_done);
        end
        start_job();
        fill_words();
        for (int k = 0; k < 11; k++) cyc();
        n_chk++;
        if ({busy, done} !== 2'b11) begin
            n_fail++;
            $display("FAIL clr_rerun_done: got busy=%b done=%b required 1 1", busy, done);
        end
        cyc();
    endtask

    task automatic test_async_reset;
        start_job();
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + b);
            cyc();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, fifo_d, fifo_en, col_valid, mac_en, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 0",
                     {in_ready, fifo_d, fifo_en, col_valid, mac_en, busy, done});
        end
        cyc();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc();
        n_chk++;
        if ({busy, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b rdy=%b required 0 0", busy, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fill_compute();
        test_stall();
`ifdef FIFO_SKEW_SCHED_PERF_EN
        test_perf();
`endif
        test_gaps();
        test_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
